// File: rtl/sdram_pkg.sv
// sdram_pkg: state encoding and default geometry shared by the SDRAM arbiter,
// its pointer block and the write/read command engines.
package sdram_pkg;

  // Arbiter states; the numeric values are visible on the arb_state debug port
  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } arb_state_t;

  // SDRAM word-address width (bank+row+col)
  localparam int SDRAM_ADDR_W      = 22;
  // Words moved by one finished write or read transfer
  localparam int SDRAM_BURST_WORDS = 256;

endpackage

// File: rtl/sdram_ptr_ctrl.sv
// sdram_ptr_ctrl: circular SDRAM write/read base pointers and stored-word
// occupancy. Advances on finished transfers only and reports whether another
// write (room for one burst) or read (one burst stored) may start.
module sdram_ptr_ctrl
  import sdram_pkg::*;
#(
  parameter int ADDR_W      = SDRAM_ADDR_W,
  parameter int BURST_WORDS = SDRAM_BURST_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_done,
  input  logic              rd_done,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   occ,
  output logic              wr_ok,
  output logic              rd_ok
);

  localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST_WORDS);
  localparam logic [ADDR_W:0]   BURST_O  = (ADDR_W+1)'(BURST_WORDS);
  // Highest occupancy that still leaves room for a whole burst
  localparam logic [ADDR_W:0]   WR_LIMIT = (ADDR_W+1)'((64'd1 << ADDR_W) - 64'(BURST_WORDS));

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   occ_q, occ_d;

  // Next pointers/occupancy; address arithmetic wraps modulo the memory size
  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    occ_d     = occ_q;
    if (wr_done) begin
      wr_addr_d = wr_addr_q + BURST_A;
      occ_d     = occ_d + BURST_O;
    end
    if (rd_done) begin
      rd_addr_d = rd_addr_q + BURST_A;
      occ_d     = occ_d - BURST_O;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      occ_q     <= '0;
    end else begin
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      occ_q     <= occ_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign rd_addr = rd_addr_q;
  assign occ     = occ_q;
  assign wr_ok   = (occ_q <= WR_LIMIT);
  assign rd_ok   = (occ_q >= BURST_O);

endmodule

// File: rtl/sdram_arbit.sv
// sdram_arbit: central SDRAM scheduler. Grants the bus to exactly one of the
// refresh, burst-write and burst-read engines (refresh first) and keeps the
// circular buffer pointers via sdram_ptr_ctrl.
// Build macro ARB_RR_EN: when defined, write and read alternate round robin
// whenever both are eligible; otherwise write always beats read.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W      = SDRAM_ADDR_W,
  parameter int BURST_WORDS = SDRAM_BURST_WORDS
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic              wr_trig,
  input  logic              rd_trig,
  input  logic              aref_end,
  input  logic              wr_end,
  input  logic              wr_fin,
  input  logic              rd_end,
  input  logic              rd_fin,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              aref_pend,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   occ,
  output logic [2:0]        arb_state
);

  arb_state_t state_q, state_d;
  logic wr_trig_dly_q, rd_trig_dly_q;
  logic wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic aref_en_q, wr_en_q, rd_en_q, aref_pend_q;
  logic wr_done, rd_done, wr_ok, rd_ok;
  logic wr_elig, rd_elig, wr_win, rd_win;

  // End pulses only count in the matching state; a stray pulse moves nothing
  assign wr_done = wr_end && wr_fin && (state_q == WRITE);
  assign rd_done = rd_end && rd_fin && (state_q == READ);

  sdram_ptr_ctrl #(
    .ADDR_W      (ADDR_W),
    .BURST_WORDS (BURST_WORDS)
  ) u_ptr (
    .clk     (sclk),
    .rst_n   (s_rst_n),
    .wr_done (wr_done),
    .rd_done (rd_done),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .occ     (occ),
    .wr_ok   (wr_ok),
    .rd_ok   (rd_ok)
  );

  // Pending flags: set on a trigger rising edge, cleared by a finished
  // transfer; a set in the same cycle as the clear wins
  always_comb begin
    wr_pend_d = wr_pend_q;
    rd_pend_d = rd_pend_q;
    if (wr_done) wr_pend_d = 1'b0;
    if (wr_trig && !wr_trig_dly_q) wr_pend_d = 1'b1;
    if (rd_done) rd_pend_d = 1'b0;
    if (rd_trig && !rd_trig_dly_q) rd_pend_d = 1'b1;
  end

  // Trigger edge-detect delays and pending flags
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wr_trig_dly_q <= 1'b0;
      rd_trig_dly_q <= 1'b0;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
    end else begin
      wr_trig_dly_q <= wr_trig;
      rd_trig_dly_q <= rd_trig;
      wr_pend_q     <= wr_pend_d;
      rd_pend_q     <= rd_pend_d;
    end
  end

  // Ineligible requests simply stay pending until the buffer level allows them
  assign wr_elig = wr_pend_q && wr_ok;
  assign rd_elig = rd_pend_q && rd_ok;

`ifdef ARB_RR_EN
  logic last_rd_q, last_rd_d;

  // Remember which of write/read was granted last
  always_comb begin
    last_rd_d = last_rd_q;
    if (state_q == ARBIT && state_d == WRITE) last_rd_d = 1'b0;
    if (state_q == ARBIT && state_d == READ)  last_rd_d = 1'b1;
  end

  // Last-grant register; starts as "read last" so the first contest goes to write
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) last_rd_q <= 1'b1;
    else          last_rd_q <= last_rd_d;
  end

  assign wr_win = wr_elig && (!rd_elig || last_rd_q);
`else
  assign wr_win = wr_elig;
`endif
  assign rd_win = rd_elig && !wr_win;

  // Next-state logic: refresh beats write/read; busy states wait for their end pulse
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    if (init_end) state_d = ARBIT;
      ARBIT: begin
        if (aref_req)    state_d = AREF;
        else if (wr_win) state_d = WRITE;
        else if (rd_win) state_d = READ;
      end
      AREF:    if (aref_end) state_d = ARBIT;
      WRITE:   if (wr_end)   state_d = ARBIT;
      READ:    if (rd_end)   state_d = ARBIT;
      default: state_d = INIT;
    endcase
  end

  // State register with registered grants that track the state exactly
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q     <= INIT;
      aref_en_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      aref_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aref_en_q   <= (state_d == AREF);
      wr_en_q     <= (state_d == WRITE);
      rd_en_q     <= (state_d == READ);
      aref_pend_q <= aref_req && (state_q == WRITE || state_q == READ);
    end
  end

  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign aref_pend = aref_pend_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: scoreboard bench for sdram_arbit. Stimulus pushes the expected
// grant (kind, pointers, occupancy) before provoking it; a monitor thread pops
// and compares on every grant rising edge. Directed state checks sit inline.
module tb_sdram_arbit;
  import sdram_pkg::*;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          s_rst_n, init_end, aref_req, wr_trig, rd_trig;
  logic          aref_end, wr_end, wr_fin, rd_end, rd_fin;
  logic          aref_en, wr_en, rd_en, aref_pend;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   occ;
  logic [2:0]    arb_state;

  typedef struct {
    logic [2:0]    kind;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [AW:0]   oc;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  bit   quiet;

  logic [AW-1:0] m_wr, m_rd;
  logic [AW:0]   m_occ;

  always #5 clk = ~clk;

  sdram_arbit dut (
    .sclk      (clk),
    .s_rst_n   (s_rst_n),
    .init_end  (init_end),
    .aref_req  (aref_req),
    .wr_trig   (wr_trig),
    .rd_trig   (rd_trig),
    .aref_end  (aref_end),
    .wr_end    (wr_end),
    .wr_fin    (wr_fin),
    .rd_end    (rd_end),
    .rd_fin    (rd_fin),
    .aref_en   (aref_en),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .aref_pend (aref_pend),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .occ       (occ),
    .arb_state (arb_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] kind, input logic [AW-1:0] wa,
                          input logic [AW-1:0] ra, input logic [AW:0] oc);
    exp_t e;
    e.kind = kind;
    e.wa   = wa;
    e.ra   = ra;
    e.oc   = oc;
    exp_q.push_back(e);
  endtask

  // Bounded wait for a state; an expired bound is a failed comparison
  task automatic wait_state(input logic [2:0] st, input int limit, input string tag);
    int n;
    n = 0;
    while (arb_state != st && n < limit) begin
      tick();
      n++;
    end
    chk(tag, arb_state, st);
  endtask

  // One-cycle end pulse for the given engine
  task automatic end_pulse(input logic [2:0] kind, input logic fin);
    if (kind == WRITE) begin wr_end = 1'b1; wr_fin = fin; end
    else if (kind == READ) begin rd_end = 1'b1; rd_fin = fin; end
    else aref_end = 1'b1;
    tick();
    wr_end = 1'b0; wr_fin = 1'b0;
    rd_end = 1'b0; rd_fin = 1'b0;
    aref_end = 1'b0;
  endtask

  // Monitor: compare each new grant against the scoreboard head
  task automatic run_monitor();
    logic pa, pw, pr;
    logic [2:0] got;
    exp_t e;
    pa = 1'b0; pw = 1'b0; pr = 1'b0;
    forever begin
      @(negedge clk);
      if (!s_rst_n) begin
        pa = 1'b0; pw = 1'b0; pr = 1'b0;
      end else begin
        if (wr_end)   chk("wr_end_state", arb_state, WRITE);
        if (rd_end)   chk("rd_end_state", arb_state, READ);
        if (aref_end) chk("aref_end_state", arb_state, AREF);
        if ((aref_en && !pa) || (wr_en && !pw) || (rd_en && !pr)) begin
          got = aref_en ? AREF : (wr_en ? WRITE : READ);
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", got, 0);
          end else begin
            e = exp_q.pop_front();
            chk("grant_kind", got, e.kind);
            chk("grant_state", arb_state, e.kind);
            chk("grant_onehot", $countones({aref_en, wr_en, rd_en}), 1);
            chk("grant_wr_addr", wr_addr, e.wa);
            chk("grant_rd_addr", rd_addr, e.ra);
            chk("grant_occ", occ, e.oc);
            if (!quiet)
              $display("TXN t=%0t kind=%0d wr_addr=%0h rd_addr=%0h occ=%0h",
                       $time, got, wr_addr, rd_addr, occ);
          end
        end
        pa = aref_en; pw = wr_en; pr = rd_en;
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0; quiet = 1'b0;
    s_rst_n = 1'b0; init_end = 1'b0; aref_req = 1'b0;
    wr_trig = 1'b0; rd_trig = 1'b0;
    aref_end = 1'b0; wr_end = 1'b0; wr_fin = 1'b0; rd_end = 1'b0; rd_fin = 1'b0;
    fork
      run_monitor();
    join_none

    // Reset values
    repeat (3) tick();
    chk("rst_state", arb_state, INIT);
    chk("rst_flags", {aref_en, wr_en, rd_en, aref_pend}, 0);
    chk("rst_occ", occ, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);

    // Refresh request before init completes is ignored
    s_rst_n = 1'b1;
    aref_req = 1'b1;
    repeat (5) tick();
    chk("init_hold", arb_state, INIT);
    chk("init_no_aref", aref_en, 0);
    aref_req = 1'b0;
    tick();
    init_end = 1'b1;
    tick();
    chk("init_to_arbit", arb_state, ARBIT);
    chk("idle_grants", {aref_en, wr_en, rd_en}, 0);
    chk("idle_occ", occ, 0);

    // Read requested on an empty buffer is held
    rd_trig = 1'b1;
    repeat (6) tick();
    chk("rd_held_empty", rd_en, 0);
    chk("rd_held_state", arb_state, ARBIT);

    // First write, then the held read becomes eligible
    push_exp(WRITE, 22'd0, 22'd0, 23'd0);
    push_exp(READ, 22'd256, 22'd0, 23'd256);
    wr_trig = 1'b1;
    tick(); tick();
    chk("wr_grant_latency", wr_en, 1);
    end_pulse(WRITE, 1'b1);
    chk("wr_addr_after_wr", wr_addr, 256);
    chk("occ_after_wr", occ, 256);
    chk("state_after_wr", arb_state, ARBIT);
    wait_state(READ, 10, "wait_read1");
    end_pulse(READ, 1'b1);
    chk("rd_addr_after_rd", rd_addr, 256);
    chk("occ_after_rd", occ, 0);
    wr_trig = 1'b0; rd_trig = 1'b0;
    tick(); tick();

    // Refresh during a write: early stop, refresh, re-grant at same address
    push_exp(WRITE, 22'd256, 22'd256, 23'd0);
    wr_trig = 1'b1;
    wait_state(WRITE, 10, "wait_write2");
    aref_req = 1'b1;
    tick();
    chk("aref_pend_in_write", aref_pend, 1);
    push_exp(AREF, 22'd256, 22'd256, 23'd0);
    push_exp(WRITE, 22'd256, 22'd256, 23'd0);
    end_pulse(WRITE, 1'b0);
    chk("early_stop_wr_addr", wr_addr, 256);
    chk("early_stop_occ", occ, 0);
    wait_state(AREF, 10, "wait_aref1");
    chk("aref_en_granted", aref_en, 1);
    end_pulse(AREF, 1'b0);
    aref_req = 1'b0;
    wait_state(WRITE, 10, "wait_write_resume");
    end_pulse(WRITE, 1'b1);
    chk("wr_addr_after_resume", wr_addr, 512);
    chk("occ_after_resume", occ, 256);
    wr_trig = 1'b0;
    tick(); tick();

    // Refresh, write and read all requested together
    push_exp(AREF, 22'd512, 22'd256, 23'd256);
`ifdef ARB_RR_EN
    push_exp(READ, 22'd512, 22'd256, 23'd256);
    push_exp(WRITE, 22'd512, 22'd512, 23'd0);
`else
    push_exp(WRITE, 22'd512, 22'd256, 23'd256);
    push_exp(READ, 22'd768, 22'd256, 23'd512);
`endif
    aref_req = 1'b1; wr_trig = 1'b1; rd_trig = 1'b1;
    wait_state(AREF, 10, "wait_aref2");
    end_pulse(AREF, 1'b0);
    aref_req = 1'b0;
`ifdef ARB_RR_EN
    wait_state(READ, 10, "wait_rr_read");
    end_pulse(READ, 1'b1);
    wait_state(WRITE, 10, "wait_rr_write");
    end_pulse(WRITE, 1'b1);
`else
    wait_state(WRITE, 10, "wait_prio_write");
    end_pulse(WRITE, 1'b1);
    wait_state(READ, 10, "wait_prio_read");
    end_pulse(READ, 1'b1);
`endif
    chk("mix_wr_addr", wr_addr, 768);
    chk("mix_rd_addr", rd_addr, 512);
    chk("mix_occ", occ, 256);
    wr_trig = 1'b0; rd_trig = 1'b0;
    tick(); tick();

    // Back-to-back finished writes until the buffer is full; the trigger
    // re-rises with each end pulse so the request survives the clear
    quiet = 1'b1;
    m_wr = 22'd768; m_rd = 22'd512; m_occ = 23'd256;
    wr_trig = 1'b1;
    tick();
    wr_trig = 1'b0;
    for (int k = 1; k <= 16383; k++) begin
      push_exp(WRITE, m_wr, m_rd, m_occ);
      wait_state(WRITE, 8, "bulk_wait");
      wr_trig = 1'b1;
      end_pulse(WRITE, 1'b1);
      wr_trig = 1'b0;
      m_wr  = m_wr + 22'd256;
      m_occ = m_occ + 23'd256;
      if (k == 16380) chk("wr_addr_top", wr_addr, 22'h3FFF00);
      if (k == 16381) chk("wr_addr_wrap", wr_addr, 0);
    end
    quiet = 1'b0;
    chk("full_wr_addr", wr_addr, 512);
    chk("full_occ", occ, 23'h400000);
    repeat (20) tick();
    chk("full_wr_held", wr_en, 0);
    chk("full_state", arb_state, ARBIT);

    // A read frees one burst; the held write then proceeds
    push_exp(READ, 22'd512, 22'd512, 23'h400000);
    push_exp(WRITE, 22'd512, 22'd768, 23'h3FFF00);
    rd_trig = 1'b1;
    wait_state(READ, 10, "wait_read_full");
    end_pulse(READ, 1'b1);
    wait_state(WRITE, 10, "wait_held_write");
    end_pulse(WRITE, 1'b1);
    chk("refill_occ", occ, 23'h400000);
    chk("refill_wr_addr", wr_addr, 768);
    chk("refill_rd_addr", rd_addr, 768);
    rd_trig = 1'b0;
    tick();

    // Asynchronous reset in the middle of a refresh
    push_exp(AREF, 22'd768, 22'd768, 23'h400000);
    aref_req = 1'b1;
    wait_state(AREF, 10, "wait_aref3");
    tick();
    #2 s_rst_n = 1'b0;
    #1;
    chk("async_rst_state", arb_state, INIT);
    chk("async_rst_aref_en", aref_en, 0);
    chk("async_rst_occ", occ, 0);
    chk("async_rst_wr_addr", wr_addr, 0);
    chk("async_rst_rd_addr", rd_addr, 0);
    aref_req = 1'b0;
    tick();
    s_rst_n = 1'b1;
    tick(); tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
